// File: rtl/dram_arbiter.sv
// Two-master arbiter for a single-port data RAM: processor and host loader share
// the RAM under round-robin arbitration, with a host bus-lock and registered outputs.
module dram_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  // processor port
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_gnt,
  output logic          p_rvalid,
  output logic [DW-1:0] p_rdata,
  // host-loader port
  input  logic          h_req,
  input  logic          h_we,
  input  logic          h_lock,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  // RAM port
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t state;
  logic   last_host;   // 1 = host won the most recent arbitration
  logic   win_host;    // owner of the access in flight
  logic   ready;       // holds off arbitration for the first edge after reset

  logic lock_active;
  logic p_elig;
  logic h_elig;
  logic grant_p;
  logic grant_h;

  // The lock only binds while the host owns the bus; on a tie the master that
  // did not win last time is served.
  always_comb begin
    lock_active = last_host && h_lock;
    p_elig      = p_req && !lock_active;
    h_elig      = h_req;
    grant_h     = h_elig && (!p_elig || !last_host);
    grant_p     = p_elig && !grant_h;
  end

  // NOTE: every register below is assigned with <= so all of them update from
  // the same pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_host <= 1'b1;
      win_host  <= 1'b0;
      ready     <= 1'b0;
      p_gnt     <= 1'b0;
      h_gnt     <= 1'b0;
      p_rvalid  <= 1'b0;
      h_rvalid  <= 1'b0;
      p_rdata   <= '0;
      h_rdata   <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      ready    <= 1'b1;
      p_rvalid <= 1'b0;
      h_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (ready && (grant_p || grant_h)) begin
            ram_we    <= grant_h ? h_we    : p_we;
            ram_addr  <= grant_h ? h_addr  : p_addr;
            ram_wdata <= grant_h ? h_wdata : p_wdata;
            win_host  <= grant_h;
            last_host <= grant_h;
            p_gnt     <= grant_p;
            h_gnt     <= grant_h;
            ram_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          p_gnt  <= 1'b0;
          h_gnt  <= 1'b0;
          ram_en <= 1'b0;
          if (ram_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          // RAM data is valid now, one cycle after the read strobe.
          if (win_host) begin
            h_rdata  <= ram_rdata;
            h_rvalid <= 1'b1;
          end else begin
            p_rdata  <= ram_rdata;
            p_rvalid <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          p_gnt  <= 1'b0;
          h_gnt  <= 1'b0;
          ram_en <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
